// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and the x0 register index.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN,
        MD_WAIT
    } haz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the ID and EX stages.
// Ports: ID rs1/rs2 and their use flags, EX rd and load flag -> hazard.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_use_rs1,
    input  logic       ifid_use_rs2,
    input  logic [4:0] idex_rd,
    input  logic       idex_memread,
    output logic       hazard
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = ifid_use_rs1 && (idex_rd == ifid_rs1);
    assign hit_rs2 = ifid_use_rs2 && (idex_rd == ifid_rs2);

    // A load into x0 never produces a value, so it cannot hazard.
    assign hazard = idex_memread && (idex_rd != REG_X0)
                  && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing: load-use stall, MUL/DIV wait with watchdog, branch flush.
// Ports: ID/EX hazard fields, branch and md_done in; enables, flushes,
// md_start/md_abort pulses, sticky md_error and perf counters out.
// Build option HAZ_PERF_EN enables the stall_cycles/flush_count counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             idex_is_md,
    input  logic             ex_branch_taken,
    input  logic             md_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_write,
    output logic             exmem_bubble,
    output logic             md_start,
    output logic             md_abort,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WD_W = $clog2(MD_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    haz_state_t      state;
    haz_state_t      state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_nxt;
    logic            err_set;
    logic            lu_hazard;

    load_use_detect u_lud (
        .ifid_rs1     (ifid_rs1),
        .ifid_rs2     (ifid_rs2),
        .ifid_use_rs1 (ifid_use_rs1),
        .ifid_use_rs2 (ifid_use_rs2),
        .idex_rd      (idex_rd),
        .idex_memread (idex_memread),
        .hazard       (lu_hazard)
    );

    // Outputs are gated by rst_n so they show the idle
    // pass-through values for the whole reset assertion.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        md_start     = 1'b0;
        md_abort     = 1'b0;
        err_set      = 1'b0;
        state_nxt    = state;
        wd_nxt       = wd_cnt;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    priority case (1'b1)
                        ex_branch_taken: begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end
                        (idex_is_md && !md_done): begin
                            md_start     = 1'b1;
                            pc_write     = 1'b0;
                            ifid_write   = 1'b0;
                            idex_write   = 1'b0;
                            exmem_bubble = 1'b1;
                            state_nxt    = MD_WAIT;
                            wd_nxt       = '0;
                        end
                        // Result ready at once: let it flow.
                        idex_is_md: begin
                        end
                        lu_hazard: begin
                            pc_write   = 1'b0;
                            ifid_write = 1'b0;
                            idex_flush = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                MD_WAIT: begin
                    priority case (1'b1)
                        md_done: begin
                            state_nxt = RUN;
                        end
                        (wd_cnt == WD_LAST): begin
                            md_abort   = 1'b1;
                            err_set    = 1'b1;
                            idex_flush = 1'b1;
                            state_nxt  = RUN;
                        end
                        default: begin
                            pc_write     = 1'b0;
                            ifid_write   = 1'b0;
                            idex_write   = 1'b0;
                            exmem_bubble = 1'b1;
                            wd_nxt       = wd_cnt + WD_W'(1);
                        end
                    endcase
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wd_cnt   <= '0;
            md_error <= 1'b0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= wd_nxt;
            if (err_set) begin
                md_error <= 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (ifid_flush || md_abort) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit (MD_TIMEOUT = 8).
// Output vector order: pc, ifid_w, idex_w, ifid_fl, idex_fl, bub, start, abort.
module tb_hazard_control_unit;

    localparam int CNT_W = 32;
`ifdef HAZ_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    localparam logic [7:0] O_RUN   = 8'b111_00000;
    localparam logic [7:0] O_LU    = 8'b001_01000;
    localparam logic [7:0] O_BR    = 8'b111_11000;
    localparam logic [7:0] O_START = 8'b000_00110;
    localparam logic [7:0] O_FRZ   = 8'b000_00100;
    localparam logic [7:0] O_ABORT = 8'b111_01001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             ifid_use_rs1;
    logic             ifid_use_rs2;
    logic [4:0]       idex_rd;
    logic             idex_memread;
    logic             idex_is_md;
    logic             ex_branch_taken;
    logic             md_done;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             idex_write;
    logic             exmem_bubble;
    logic             md_start;
    logic             md_abort;
    logic             md_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    logic [7:0] outs;
    int         n_checks = 0;
    int         n_fail   = 0;

    assign outs = {pc_write, ifid_write, idex_write, ifid_flush,
                   idex_flush, exmem_bubble, md_start, md_abort};

    always #5 clk = ~clk;

    hazard_control_unit #(
        .MD_TIMEOUT (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ifid_rs1        (ifid_rs1),
        .ifid_rs2        (ifid_rs2),
        .ifid_use_rs1    (ifid_use_rs1),
        .ifid_use_rs2    (ifid_use_rs2),
        .idex_rd         (idex_rd),
        .idex_memread    (idex_memread),
        .idex_is_md      (idex_is_md),
        .ex_branch_taken (ex_branch_taken),
        .md_done         (md_done),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .idex_write      (idex_write),
        .exmem_bubble    (exmem_bubble),
        .md_start        (md_start),
        .md_abort        (md_abort),
        .md_error        (md_error),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        ifid_rs1        = '0;
        ifid_rs2        = '0;
        ifid_use_rs1    = 1'b0;
        ifid_use_rs2    = 1'b0;
        idex_rd         = '0;
        idex_memread    = 1'b0;
        idex_is_md      = 1'b0;
        ex_branch_taken = 1'b0;
        md_done         = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        idex_memread = 1'b1;
        idex_rd      = rd;
        ifid_rs2     = 5'd5;
        ifid_use_rs2 = 1'b1;
    endtask

    // Inputs change 1 ns after the edge; outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_in();
        set_lu(5'd5);
        idex_is_md = 1'b1;
        #12;
        check("rst_outs", 32'(outs), 32'(O_RUN));
        check("rst_err", 32'(md_error), 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        check("rst_flush", flush_count, 32'd0);
        #1;
        rst_n = 1'b1;
        clr_in();
        tick();

        // Load-use on rs2: one stall, then the bubble clears it.
        set_lu(5'd5);
        #1 check("lu_rs2", 32'(outs), 32'(O_LU));
        tick();
        clr_in();
        #1 check("lu_clear", 32'(outs), 32'(O_RUN));
        tick();

        // Load into x0 never stalls.
        set_lu(5'd0);
        ifid_rs2 = 5'd0;
        #1 check("lu_x0", 32'(outs), 32'(O_RUN));
        tick();

        // rs1 match only counts when rs1 is used.
        clr_in();
        idex_memread = 1'b1;
        idex_rd      = 5'd7;
        ifid_rs1     = 5'd7;
        ifid_use_rs1 = 1'b1;
        #1 check("lu_rs1", 32'(outs), 32'(O_LU));
        ifid_use_rs1 = 1'b0;
        #1 check("lu_rs1_unused", 32'(outs), 32'(O_RUN));
        tick();

        // Branch wins over load-use.
        clr_in();
        set_lu(5'd5);
        ex_branch_taken = 1'b1;
        #1 check("br_lu", 32'(outs), 32'(O_BR));
        tick();

        // MUL/DIV done in the same cycle: no start, no stall.
        clr_in();
        idex_is_md = 1'b1;
        md_done    = 1'b1;
        #1 check("md_imm", 32'(outs), 32'(O_RUN));
        tick();

        // MUL/DIV with 4 wait cycles.
        clr_in();
        idex_is_md = 1'b1;
        #1 check("md_start", 32'(outs), 32'(O_START));
        tick();
        for (int i = 0; i < 4; i++) begin
            ex_branch_taken = (i == 2);
            #1 check($sformatf("md_wait%0d", i), 32'(outs), 32'(O_FRZ));
            tick();
        end
        ex_branch_taken = 1'b0;
        md_done         = 1'b1;
        set_lu(5'd5);
        #1 check("md_done", 32'(outs), 32'(O_RUN));
        tick();
        clr_in();
        #1 check("md_back_run", 32'(outs), 32'(O_RUN));
        tick();

        // Watchdog: abort on the 8th MD_WAIT cycle.
        idex_is_md = 1'b1;
        #1 check("to_start", 32'(outs), 32'(O_START));
        tick();
        for (int i = 0; i < 7; i++) begin
            #1 check($sformatf("to_wait%0d", i), 32'(outs), 32'(O_FRZ));
            tick();
        end
        #1 check("to_abort", 32'(outs), 32'(O_ABORT));
        check("to_err_pre", 32'(md_error), 32'd0);
        tick();
        clr_in();
        #1 check("to_err_set", 32'(md_error), 32'd1);
        check("to_run", 32'(outs), 32'(O_RUN));
        tick();
        tick();
        check("to_err_sticky", 32'(md_error), 32'd1);

        // Done on the timeout cycle beats the abort.
        idex_is_md = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        md_done = 1'b1;
        #1 check("to_vs_done", 32'(outs), 32'(O_RUN));
        tick();

        // Asynchronous reset in the middle of a wait.
        clr_in();
        idex_is_md = 1'b1;
        tick();
        tick();
        #1 check("mid_frozen", 32'(outs), 32'(O_FRZ));
        #1 rst_n = 1'b0;
        #1 check("mid_rst_outs", 32'(outs), 32'(O_RUN));
        check("mid_rst_err", 32'(md_error), 32'd0);
        check("mid_rst_stall", stall_cycles, 32'd0);
        #2 rst_n = 1'b1;
        clr_in();
        #1 check("mid_rst_run", 32'(outs), 32'(O_RUN));
        tick();

        // One load-use stall and one branch flush.
        set_lu(5'd5);
        tick();
        clr_in();
        ex_branch_taken = 1'b1;
        tick();
        clr_in();
        tick();
        check("perf_stall", stall_cycles, 32'(PERF));
        check("perf_flush", flush_count, 32'(PERF));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; sits beside the operand-forwarding logic and drives the pipeline-register write enables and flushes.
- Detects load-use hazards, sequences a multi-cycle MUL/DIV unit in EX via a start/done handshake, and flushes on taken branches.
- Guards the MUL/DIV wait with a watchdog timeout.

Parameters:
- MD_TIMEOUT, 64, maximum cycles spent in MD_WAIT before abort; must be >= 2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- ifid_rs1  input  5  rs1 of the instruction in ID
- ifid_rs2  input  5  rs2 of the instruction in ID
- ifid_use_rs1  input  1  the ID instruction reads rs1
- ifid_use_rs2  input  1  the ID instruction reads rs2
- idex_rd  input  5  rd of the instruction in EX
- idex_memread  input  1  the EX instruction is a load
- idex_is_md  input  1  the EX instruction is MUL/DIV/REM
- ex_branch_taken  input  1  EX resolved a taken branch or jump
- md_done  input  1  MUL/DIV result valid this cycle
- pc_write  output  1  PC update enable
- ifid_write  output  1  IF/ID register enable
- ifid_flush  output  1  zero the IF/ID register
- idex_flush  output  1  insert a bubble into ID/EX
- idex_write  output  1  ID/EX register enable
- exmem_bubble  output  1  insert a bubble into EX/MEM
- md_start  output  1  one-cycle start pulse to MUL/DIV
- md_abort  output  1  one-cycle abort pulse to MUL/DIV on timeout
- md_error  output  1  sticky timeout flag
- stall_cycles  output  CNT_W  performance counter
- flush_count  output  CNT_W  performance counter

Behaviour:
- Reset: state RUN, wd_cnt 0, md_error 0, counters 0.
- Output values while rst_n is low: pc_write 1, ifid_write 1, idex_write 1, all flush, bubble and pulse outputs 0.
- Every output except md_error and the counters is combinational from state and inputs.
- Load-use condition: idex_memread && idex_rd != 0 && ((idex_rd == ifid_rs1 && ifid_use_rs1) || (idex_rd == ifid_rs2 && ifid_use_rs2)).
- RUN, checked in priority order:
  1. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_write=1. Stay in RUN. Branch wins over load-use and over idex_is_md.
  2. idex_is_md && !md_done: md_start=1, pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1. Next state MD_WAIT, wd_cnt<=0.
  3. idex_is_md && md_done in the same cycle: no stall; the pipeline advances. Stay in RUN, no md_start.
  4. Load-use: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble; the hazard clears on the next cycle.
  5. Otherwise: all enables 1, flushes 0.
- MD_WAIT:
  - md_done=0 and wd_cnt < MD_TIMEOUT-1: freeze (pc_write, ifid_write, idex_write all 0), exmem_bubble=1, wd_cnt increments.
  - md_done=1: release the freeze this cycle (all enables 1, exmem_bubble=0) so the result enters EX/MEM. Next state RUN. Load-use is not evaluated in this cycle.
  - md_done=0 and wd_cnt == MD_TIMEOUT-1: md_abort=1, md_error<=1, idex_flush=1, release the freeze. Next state RUN.
  - md_done and timeout in the same cycle: md_done wins; no abort.
  - md_start is never asserted in MD_WAIT.
- ex_branch_taken in MD_WAIT cannot occur, because the EX instruction is a MUL/DIV. If it is asserted anyway, it is ignored.
- md_error stays set until reset.
- Asynchronous reset mid-MD_WAIT returns to RUN immediately. No md_abort is issued; the MUL/DIV unit is reset by the same rst_n.

Optional Feature:
- Macro: HAZ_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_count increments on every cycle with ifid_flush=1 or md_abort=1.
  - Both counters wrap at 2^CNT_W.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- hazard_pkg contains:
  - typedef enum logic [0:0] {RUN, MD_WAIT} haz_state_t;
  - localparam REG_X0 = 5'd0.
- One sub-module, load_use_detect: combinational; inputs are the ID and EX register fields; output is the 1-bit load-use hazard.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1 -> exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1; with idex_rd=0 -> no stall.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with the load-use condition true -> ifid_flush=1, idex_flush=1, pc_write=1, no stall.
- MUL/DIV with done after 4 waits: idex_is_md=1 -> md_start pulses once, 4 frozen cycles with exmem_bubble=1, enables high on the md_done cycle, then RUN.
- MUL/DIV done immediately: idex_is_md=1 and md_done=1 in the same cycle -> no md_start, no stall.
- Timeout with MD_TIMEOUT=8 and md_done held at 0 -> md_abort pulses on the 8th MD_WAIT cycle; md_error=1 and stays 1; RUN resumes.
- Reset mid-wait: rst_n low during MD_WAIT -> outputs immediately return to their reset values; with HAZ_PERF_EN defined, a load-use and a branch produce stall_cycles=1 and flush_count=1.
